// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum: folds each packet of words into one checksum and
// reports it with the word count and an overlength flag.
module xor_checksum_unit #(
  parameter  int WIDTH   = 16,
  parameter  int MAX_LEN = 64,
  parameter  int MODE    = 0,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_len,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_len;
  logic             r_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_fold;

  assign w_accept = in_valid && (r_state != S_HOLD);

  // Rotate written with shifts so a WIDTH of 1 still elaborates.
  generate
    if (MODE == 1) begin : g_rotate
      assign w_fold = ((r_acc << 1) | (r_acc >> (WIDTH - 1))) ^ in_data;
    end else begin : g_plain
      assign w_fold = r_acc ^ in_data;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= in_data;
            r_len   <= CW'(1);
            r_err   <= 1'b0;
            r_state <= in_last ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_fold;
            // Overlength words still fold in; the count saturates and flags.
            if (r_len == CW'(MAX_LEN)) begin
              r_err <= 1'b1;
            end else begin
              r_len <= r_len + CW'(1);
            end
            if (in_last) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign out_sum   = r_acc;
  assign out_len   = r_len;
  assign out_err   = r_err;

endmodule
